// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t RUN  = 2'b01;
    localparam state_t DONE = 2'b10;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the bit-slice datapath of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Pure combinational sum and majority carry
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, a carry flop closing the loop,
// operand/sum shift registers and a bit counter, with valid/ready on both sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic               fa_sum, fa_cout;
    logic               last_bit;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (count_q == CNT_W'(WIDTH - 1));

    // State and datapath registers; asynchronous clear abandons any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH cycles of RUN, hold DONE until drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift one bit pair per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    count_d = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                count_d = count_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Handshake outputs decode from state; result taken straight from the flops
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = carry_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances, latency,
// carry chain, backpressure, mid-operation reset and a handshake stream.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [7:0] a, b, sum;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_sa8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    serial_adder #(.WIDTH(1)) u_sa1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation, entered at #1 after a posedge with the DUT idle.
    // hold > 0 keeps out_ready low for that many cycles once the result is up.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input logic [7:0] esum, input logic ecout, input int hold);
        int lat;
        out_ready = (hold == 0);
        a = ia; b = ib; cin = icin; in_valid = 1'b1;
        chk("op8_in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ia; b = ~ib; cin = ~icin;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("op8_latency", lat, 8);
        chk("op8_sum", sum, esum);
        chk("op8_cout", cout, ecout);
        chk("op8_in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                in_valid = 1'b1; a = 8'hAA; b = 8'h11; cin = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum", sum, esum);
            chk("bp_cout", cout, ecout);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_in_ready", in_ready, 1);
        chk("drain_out_valid", out_valid, 0);
    endtask

    task automatic op1(input logic ia, input logic ib, input logic icin,
                       input logic esum, input logic ecout);
        int lat;
        out_ready1 = 1'b1;
        a1 = ia; b1 = ib; cin1 = icin; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        a1 = ~ia; b1 = ~ib; cin1 = ~icin;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("op1_latency", lat, 1);
        chk("op1_sum", sum1, esum);
        chk("op1_cout", cout1, ecout);
        @(posedge clk); #1;
        chk("op1_drain_in_ready", in_ready1, 1);
    endtask

    initial begin
        int         accepted;
        int         drained;
        int         cyc;
        logic [8:0] q[$];
        logic [8:0] exp;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic add and carry chain
        op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0);

        // Backpressure with an ignored in_valid pulse, then a fresh op
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5);
        op8(8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 0);

        // Reset three cycles into RUN
        out_ready = 1'b1;
        a = 8'hF0; b = 8'h0F; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("post_rst_no_result", out_valid, 0);
        end
        op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);

        // WIDTH=1 instance
        op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        op1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Stream with random in_valid/out_ready; results must come back in order
        accepted = 0;
        drained  = 0;
        cyc      = 0;
        while ((accepted < 1000 || q.size() > 0) && cyc < 60000) begin
            in_valid  = (accepted < 1000) && ($urandom_range(0, 1) == 1);
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            if (in_valid && in_ready) begin
                q.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
                accepted++;
            end
            if (out_valid && out_ready) begin
                drained++;
                if (q.size() > 0) begin
                    exp = q.pop_front();
                    chk("stream_result", {cout, sum}, exp);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("stream_accepted", accepted, 1000);
        chk("stream_drained", drained, 1000);
        chk("stream_pending", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial W-bit adder with valid/ready handshakes on both sides.
- Accepts two W-bit operands and a carry-in, then feeds one bit pair per cycle (LSB first) into a single full_adder cell. A carry flop closes the loop around that cell.
- Returns the W-bit sum and carry-out.
- Sits between operand producers and result consumers in area-constrained datapaths where a ripple array of W full_adder cells is too large.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range ≥1.
- CNT_W, (WIDTH>1 ? $clog2(WIDTH) : 1), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a, b, cin valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  sum/cout valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  a + b + cin, low WIDTH bits.
- cout  out  1  carry out of bit WIDTH-1.

Behaviour:
- Single clock domain. rst asynchronous active-high: on assertion all flops clear immediately.
  - State is IDLE.
  - Shift registers, count, carry, sum and cout are all 0.
  - out_valid is 0.
  - in_ready decodes from state, so it reads 1 during and after reset. No capture occurs while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On clk edge with in_valid&in_ready: a_sh<=a, b_sh<=b, carry<=cin, count<=0, sum_sh<=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - The full_adder inputs are a_sh[0], b_sh[0] and carry.
  - Each edge: sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}; carry<=fa_cout; a_sh and b_sh shift right by 1 with zero fill; count<=count+1.
  - When count==WIDTH-1 at the edge, go to DONE. Bits are processed LSB first, exactly WIDTH RUN cycles.
- DONE:
  - out_valid=1, in_ready=0.
  - sum=sum_sh and cout=carry, held stable until the handshake.
  - On edge with out_ready=1: go to IDLE.
- sum and cout may show intermediate values outside DONE; consumers qualify them with out_valid only.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- Minimum initiation interval: WIDTH+2 cycles. There is no accept in the same cycle as result drain.
- Backpressure: out_ready low holds DONE indefinitely, with outputs stable and in_ready=0.
- in_valid while in_ready=0: ignored; the operands are not captured.
- Operand inputs are sampled only on the accepting edge. Later changes to a, b or cin have no effect.
- Arithmetic:
  - Result is modulo 2^WIDTH, and cout is the true carry out.
  - {cout,sum} == a+b+cin exactly, (WIDTH+1)-bit.
- WIDTH=1: one RUN cycle (count is 0, which equals WIDTH-1), then DONE.
- Reset mid-RUN or mid-DONE: the operation is abandoned and no result is emitted. The next accepted operation is correct.
- out_ready high while not in DONE: no effect.

Decomposition:
- Package serial_adder_pkg: state encoding localparams IDLE=2'b00, RUN=2'b01, DONE=2'b10; any shared handshake typedefs.
- Sub-module: instantiate the team's existing full_adder cell (ports a, b, cin, sum, cout) once as the bit-slice datapath. The serial_adder top contains only the FSM, shift registers, counter and carry flop.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 → out_valid high exactly 8 cycles after accept; sum=0x96, cout=0; in_ready returns 1 one cycle after drain.
2. WIDTH=8 carry chain:
   - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
   - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
   - a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
3. Backpressure: a=0x12, b=0x34, cin=0; hold out_ready=0 for 5 cycles after out_valid → sum=0x46, cout=0 stable all cycles, in_ready=0; in_valid pulsed with a=0xAA is ignored; drain, then the next op computes fresh.
4. Reset mid-operation: accept a=0xF0, b=0x0F, cin=1; assert rst asynchronously after 3 RUN cycles → out_valid=0, sum=0, cout=0 immediately; after release, a=0x01, b=0x02, cin=0 → sum=0x03, cout=0.
5. WIDTH=1 instance: a=1, b=1, cin=1 → sum=1, cout=1, out_valid 1 cycle after accept. a=1, b=0, cin=0 → sum=1, cout=0.
6. Randomised back-to-back stream: 1000 ops, WIDTH=8, random in_valid/out_ready → every {cout,sum} matches a+b+cin in order; no result lost or duplicated.
